// File: rtl/decode_stage_if.sv
// Bus between the decode stage and its neighbours: fetch-side inputs, register
// file read port, hazard/redirect controls and the registered ID/EX bundle.
interface decode_stage_if #(
   parameter int PC_W    = 30,
   parameter int ALUOP_W = 3
);
   logic [31:0]        if_instruction;
   logic [PC_W-1:0]    if_pc_seq;
   logic               if_valid;
   logic               flush;

   logic [4:0]         rf_addr_a;
   logic [4:0]         rf_addr_b;
   logic [31:0]        rf_data_a;
   logic [31:0]        rf_data_b;

   logic               stall;
   logic               id_redirect;
   logic [PC_W-1:0]    id_redirect_pc;

   logic               ex_valid;
   logic [PC_W-1:0]    ex_pc_seq;
   logic [31:0]        ex_data_a;
   logic [31:0]        ex_data_b;
   logic [31:0]        ex_imm32;
   logic [4:0]         ex_shamt;
   logic [4:0]         ex_dest;
   logic [ALUOP_W-1:0] ex_alu_op;
   logic               ex_alu_src;
   logic               ex_reg_write;
   logic               ex_mem_read;
   logic               ex_mem_write;
   logic               ex_mem_to_reg;
   logic               ex_branch;
   logic               ex_illegal;

   // Environment side: fetch unit, register file and EX stage.
   modport master (
      output if_instruction, if_pc_seq, if_valid, flush, rf_data_a, rf_data_b,
      input  rf_addr_a, rf_addr_b, stall, id_redirect, id_redirect_pc,
      input  ex_valid, ex_pc_seq, ex_data_a, ex_data_b, ex_imm32, ex_shamt,
      input  ex_dest, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read,
      input  ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal
   );

   // Decode stage side.
   modport slave (
      input  if_instruction, if_pc_seq, if_valid, flush, rf_data_a, rf_data_b,
      output rf_addr_a, rf_addr_b, stall, id_redirect, id_redirect_pc,
      output ex_valid, ex_pc_seq, ex_data_a, ex_data_b, ex_imm32, ex_shamt,
      output ex_dest, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read,
      output ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, instruction decoder, load-use hazard detection,
// jump resolution in ID and the registered ID/EX control/data bundle.
module decode_stage #(
   parameter int PC_W    = 30,
   parameter int ALUOP_W = 3
) (
   input  logic           clk,
   input  logic           reset,
   decode_stage_if.slave  bus
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [ALUOP_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b111;

   logic               ifid_valid;
   logic [31:0]        ifid_instr;
   logic [PC_W-1:0]    ifid_pc_seq;

   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic [4:0]         rs;
   logic [4:0]         rt;
   logic [4:0]         rd;

   logic [ALUOP_W-1:0] dec_alu_op;
   logic               dec_alu_src;
   logic               dec_reg_write;
   logic               dec_mem_read;
   logic               dec_mem_write;
   logic               dec_mem_to_reg;
   logic               dec_branch;
   logic               dec_illegal;
   logic [4:0]         dec_dest;
   logic               reads_rt;
   logic               is_jump;

   logic               hazard;
   logic               ex_bubble;

   assign opcode = ifid_instr[31:26];
   assign rs     = ifid_instr[25:21];
   assign rt     = ifid_instr[20:16];
   assign rd     = ifid_instr[15:11];
   assign funct  = ifid_instr[5:0];

   assign bus.rf_addr_a = rs;
   assign bus.rf_addr_b = rt;

   // Jumps read no registers, so they never wait on a load; this also keeps
   // stall and redirect from being raised together.
   assign hazard = ifid_valid && !is_jump && bus.ex_valid && bus.ex_mem_read &&
                   (bus.ex_dest != 5'd0) &&
                   ((bus.ex_dest == rs) || (reads_rt && (bus.ex_dest == rt)));

   assign bus.stall          = hazard && !bus.flush;
   assign bus.id_redirect    = ifid_valid && is_jump && !bus.flush;
   assign bus.id_redirect_pc = {ifid_pc_seq[PC_W-1:PC_W-4], ifid_instr[25:0]};

   assign ex_bubble = bus.flush || hazard || !ifid_valid || is_jump;

   // Decode the IF/ID word into EX controls; unknown encodings become illegal.
   always_comb begin
      dec_alu_op     = '0;
      dec_alu_src    = 1'b0;
      dec_reg_write  = 1'b0;
      dec_mem_read   = 1'b0;
      dec_mem_write  = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_branch     = 1'b0;
      dec_illegal    = 1'b0;
      dec_dest       = 5'd0;
      reads_rt       = 1'b0;
      is_jump        = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            reads_rt      = 1'b1;
            dec_dest      = rd;
            dec_reg_write = 1'b1;
            case (funct)
               F_ADD:   dec_alu_op = ALU_ADD;
               F_SUB:   dec_alu_op = ALU_SUB;
               F_AND:   dec_alu_op = ALU_AND;
               F_OR:    dec_alu_op = ALU_OR;
               F_SLT:   dec_alu_op = ALU_SLT;
               default: begin
                  dec_illegal   = 1'b1;
                  dec_dest      = 5'd0;
                  dec_reg_write = 1'b0;
               end
            endcase
         end
         OP_LW: begin
            dec_alu_op     = ALU_ADD;
            dec_alu_src    = 1'b1;
            dec_dest       = rt;
            dec_mem_read   = 1'b1;
            dec_mem_to_reg = 1'b1;
            dec_reg_write  = 1'b1;
         end
         OP_SW: begin
            reads_rt      = 1'b1;
            dec_alu_op    = ALU_ADD;
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
         end
         OP_BEQ: begin
            reads_rt   = 1'b1;
            dec_alu_op = ALU_SUB;
            dec_branch = 1'b1;
         end
         OP_ADDI: begin
            dec_alu_op    = ALU_ADD;
            dec_alu_src   = 1'b1;
            dec_dest      = rt;
            dec_reg_write = 1'b1;
         end
         OP_J: begin
            is_jump = 1'b1;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   // IF/ID register: flush squashes, stall holds, a taken jump squashes the slot
   // fetched behind it, otherwise capture the fetched word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ifid_valid  <= 1'b0;
         ifid_instr  <= '0;
         ifid_pc_seq <= '0;
      end else if (bus.flush || bus.id_redirect) begin
         ifid_valid  <= 1'b0;
         ifid_instr  <= '0;
      end else if (!bus.stall) begin
         ifid_valid  <= bus.if_valid;
         ifid_instr  <= bus.if_valid ? bus.if_instruction : 32'd0;
         ifid_pc_seq <= bus.if_pc_seq;
      end
   end

   // ID/EX register: a bubble clears the whole bundle, otherwise issue the decode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset || ex_bubble) begin
         bus.ex_valid      <= 1'b0;
         bus.ex_pc_seq     <= '0;
         bus.ex_data_a     <= '0;
         bus.ex_data_b     <= '0;
         bus.ex_imm32      <= '0;
         bus.ex_shamt      <= '0;
         bus.ex_dest       <= '0;
         bus.ex_alu_op     <= '0;
         bus.ex_alu_src    <= 1'b0;
         bus.ex_reg_write  <= 1'b0;
         bus.ex_mem_read   <= 1'b0;
         bus.ex_mem_write  <= 1'b0;
         bus.ex_mem_to_reg <= 1'b0;
         bus.ex_branch     <= 1'b0;
         bus.ex_illegal    <= 1'b0;
      end else begin
         bus.ex_valid      <= 1'b1;
         bus.ex_pc_seq     <= ifid_pc_seq;
         bus.ex_data_a     <= bus.rf_data_a;
         bus.ex_data_b     <= bus.rf_data_b;
         bus.ex_imm32      <= {{16{ifid_instr[15]}}, ifid_instr[15:0]};
         bus.ex_shamt      <= ifid_instr[10:6];
         bus.ex_dest       <= dec_dest;
         bus.ex_alu_op     <= dec_alu_op;
         bus.ex_alu_src    <= dec_alu_src;
         bus.ex_reg_write  <= dec_reg_write && (dec_dest != 5'd0);
         bus.ex_mem_read   <= dec_mem_read;
         bus.ex_mem_write  <= dec_mem_write;
         bus.ex_mem_to_reg <= dec_mem_to_reg;
         bus.ex_branch     <= dec_branch;
         bus.ex_illegal    <= dec_illegal;
      end
   end

endmodule
